dmem_resp: RTL and testbench

- Multi-cycle responder on the core's memory-stage data port: the slave end of the load/store interface the pipeline drives.
- Accepts one load or store per transaction and applies RV32I byte/half/word lane handling selected by funct3.
- Holds the request for a programmable latency, then returns one response pulse with read data or an error flag.
- Raises `busy` so the hazard unit stalls the pipeline until the response cycle.

---
 rtl/dmem_resp_if.sv | 24 ++
 rtl/dmem_resp.sv | 155 +++++++++++++++
 tb/tb_dmem_resp.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_resp_if.sv
// Load/store port between the pipeline memory stage (master) and a data-memory responder (slave).
// The request is held by the master until the single-cycle response strobe.
interface dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder with RV32I byte/half/word lane handling.
// One request per IDLE->(WAIT)->RESP pass; write and read both happen on the edge entering RESP.
module dmem_resp #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       reset,
  dmem_resp_if.slave bus
);
  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);
  localparam bit          ONE_CYCLE = (LATENCY == 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  funct3_reg;
  logic        err_reg;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_word_reg;

  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_f3;
  logic [31:0] off;
  logic        err_c;
  logic        sel_err;
  logic        enter_resp;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wlane;

  // Live inputs in IDLE only matter when LATENCY=1 (the accept edge is also the RESP-entry edge).
  always_comb begin
    sel_we    = we_reg;
    sel_addr  = addr_reg;
    sel_wdata = wdata_reg;
    sel_f3    = funct3_reg;
    if (state_reg == IDLE) begin
      sel_we    = bus.req_we;
      sel_addr  = bus.req_addr;
      sel_wdata = bus.req_wdata;
      sel_f3    = bus.req_funct3;
    end
  end

  assign off = sel_addr - BASE_ADDR;
  assign idx = off[AW+1:2];

  always_comb begin
    err_c = (sel_addr < BASE_ADDR) || (off >= SPAN);
    case (sel_f3)
      3'b000:  ;
      3'b001:  err_c = err_c | off[0];
      3'b010:  err_c = err_c | (|off[1:0]);
      3'b100:  err_c = err_c | sel_we;
      3'b101:  err_c = err_c | sel_we | off[0];
      default: err_c = 1'b1;
    endcase
  end

  assign sel_err    = (state_reg == IDLE) ? err_c : err_reg;
  assign enter_resp = reset &&
                      ((state_reg == IDLE && bus.req_valid && ONE_CYCLE) ||
                       (state_reg == WAIT && cnt_reg == 4'd1));

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign be[gi] = (sel_f3[1:0] == 2'b10) ||
                      (sel_f3[1:0] == 2'b01 && off[1] == LANE[1]) ||
                      (sel_f3[1:0] == 2'b00 && off[1:0] == LANE);
      assign wlane[gi*8 +: 8] = (sel_f3[1:0] == 2'b00) ? sel_wdata[7:0] :
                                (sel_f3[1:0] == 2'b01) ? sel_wdata[8*(gi%2) +: 8] :
                                                         sel_wdata[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      we_reg     <= 1'b0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      funct3_reg <= 3'd0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (bus.req_valid) begin
          we_reg     <= bus.req_we;
          addr_reg   <= bus.req_addr;
          wdata_reg  <= bus.req_wdata;
          funct3_reg <= bus.req_funct3;
          err_reg    <= err_c;
          cnt_reg    <= CNT_INIT;
          state_reg  <= ONE_CYCLE ? RESP : WAIT;
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) state_reg <= RESP;
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Array has no reset so it maps onto block RAM; the read port is registered.
  always_ff @(posedge clk) begin
    if (enter_resp) begin
      if (sel_we && !sel_err) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mem[idx][i*8 +: 8] <= wlane[i*8 +: 8];
      end else begin
        rd_word_reg <= mem[idx];
      end
    end
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  always_comb begin
    case (addr_reg[1:0])
      2'd0:    byte_sel = rd_word_reg[7:0];
      2'd1:    byte_sel = rd_word_reg[15:8];
      2'd2:    byte_sel = rd_word_reg[23:16];
      default: byte_sel = rd_word_reg[31:24];
    endcase
    half_sel = addr_reg[1] ? rd_word_reg[31:16] : rd_word_reg[15:0];
    case (funct3_reg)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = rd_word_reg;
    endcase
  end

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_err   = (state_reg == RESP) && err_reg;
  assign bus.rsp_rdata = (state_reg == RESP && !we_reg && !err_reg) ? load_ext : 32'd0;
  assign bus.busy      = bus.req_valid && !bus.rsp_valid;
endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: three instances (LATENCY 1/2/3) share stimulus, selected by sel.
// Each test task drives its scenario and compares against hand-computed values.
module tb_dmem_resp;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_funct3 = 3'd0;
  int          sel = 2;
  int          n_checks = 0;
  int          n_fail = 0;

  logic        m_ready, m_valid, m_err, m_busy;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  dmem_resp_if if1 ();
  dmem_resp_if if2 ();
  dmem_resp_if if3 ();

  assign if1.req_valid = req_valid && (sel == 1);
  assign if2.req_valid = req_valid && (sel == 2);
  assign if3.req_valid = req_valid && (sel == 3);
  assign if1.req_we = req_we;  assign if2.req_we = req_we;  assign if3.req_we = req_we;
  assign if1.req_addr = req_addr;  assign if2.req_addr = req_addr;  assign if3.req_addr = req_addr;
  assign if1.req_wdata = req_wdata;  assign if2.req_wdata = req_wdata;  assign if3.req_wdata = req_wdata;
  assign if1.req_funct3 = req_funct3;  assign if2.req_funct3 = req_funct3;  assign if3.req_funct3 = req_funct3;

  assign m_ready = (sel == 1) ? if1.req_ready : (sel == 2) ? if2.req_ready : if3.req_ready;
  assign m_valid = (sel == 1) ? if1.rsp_valid : (sel == 2) ? if2.rsp_valid : if3.rsp_valid;
  assign m_rdata = (sel == 1) ? if1.rsp_rdata : (sel == 2) ? if2.rsp_rdata : if3.rsp_rdata;
  assign m_err   = (sel == 1) ? if1.rsp_err   : (sel == 2) ? if2.rsp_err   : if3.rsp_err;
  assign m_busy  = (sel == 1) ? if1.busy      : (sel == 2) ? if2.busy      : if3.busy;

  dmem_resp #(.DEPTH_WORDS(64), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  dmem_resp #(.DEPTH_WORDS(64), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));
  dmem_resp #(.DEPTH_WORDS(64), .LATENCY(3), .BASE_ADDR(32'h0)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

  // Drives one request and holds it until rsp_valid; lat counts cycles from the accept cycle.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output int lat, output logic [31:0] rdata,
                         output logic err, output logic hs_ok);
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
    lat = -1; rdata = 32'd0; err = 1'b0; hs_ok = 1'b1;
    #1;
    if (!m_busy || !m_ready) hs_ok = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (m_valid) begin
        lat = i; rdata = m_rdata; err = m_err;
        if (m_busy) hs_ok = 1'b0;
        break;
      end
      if (!m_busy || m_ready) hs_ok = 1'b0;
    end
    req_valid = 1'b0;
    $display("txn lat%0d we=%0b f3=%03b addr=%h wdata=%h -> cycles=%0d rdata=%h err=%0b",
             sel, we, f3, addr, wdata, lat, rdata, err);
  endtask

  task automatic test_reset;
    sel = 2; reset = 1'b0; req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", m_ready); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
    n_checks++; if (m_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", m_rdata); end
    n_checks++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", m_err); end
    n_checks++; if (m_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", m_busy); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (m_ready !== 1'b1 || m_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset: ready=%b valid=%b expected 1/0", m_ready, m_valid); end
  endtask

  task automatic test_word;
    int lat; logic [31:0] rd; logic er, ok;
    sel = 2;
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, lat, rd, er, ok);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d expected 2", lat); end
    n_checks++; if (er !== 1'b0 || rd !== 32'd0) begin n_fail++; $display("FAIL sw_rsp: err=%b rdata=%h expected 0/0", er, rd); end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sw_busy: handshake got %b expected 1", ok); end
    run_txn(1'b0, 32'h10, 32'd0, 3'b010, lat, rd, er, ok);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d expected 2", lat); end
    n_checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL lw_data: got %h err=%b expected deadbeef/0", rd, er); end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL lw_busy: handshake got %b expected 1", ok); end
  endtask

  task automatic test_subword;
    int lat; logic [31:0] rd; logic er, ok;
    sel = 2;
    run_txn(1'b0, 32'h13, 32'd0, 3'b000, lat, rd, er, ok);
    n_checks++; if (rd !== 32'hFFFFFFDE || er) begin n_fail++; $display("FAIL lb_13: got %h expected ffffffde", rd); end
    run_txn(1'b0, 32'h13, 32'd0, 3'b100, lat, rd, er, ok);
    n_checks++; if (rd !== 32'h000000DE || er) begin n_fail++; $display("FAIL lbu_13: got %h expected 000000de", rd); end
    run_txn(1'b0, 32'h12, 32'd0, 3'b001, lat, rd, er, ok);
    n_checks++; if (rd !== 32'hFFFFDEAD || er) begin n_fail++; $display("FAIL lh_12: got %h expected ffffdead", rd); end
    run_txn(1'b0, 32'h10, 32'd0, 3'b101, lat, rd, er, ok);
    n_checks++; if (rd !== 32'h0000BEEF || er) begin n_fail++; $display("FAIL lhu_10: got %h expected 0000beef", rd); end
    run_txn(1'b0, 32'h10, 32'd0, 3'b000, lat, rd, er, ok);
    n_checks++; if (rd !== 32'hFFFFFFEF || er) begin n_fail++; $display("FAIL lb_10: got %h expected ffffffef", rd); end
  endtask

  task automatic test_partial_store;
    int lat; logic [31:0] rd; logic er, ok;
    sel = 2;
    run_txn(1'b1, 32'h11, 32'hFFFFFF55, 3'b000, lat, rd, er, ok);
    n_checks++; if (er !== 1'b0 || lat !== 2) begin n_fail++; $display("FAIL sb_rsp: err=%b cycles=%0d expected 0/2", er, lat); end
    run_txn(1'b0, 32'h10, 32'd0, 3'b010, lat, rd, er, ok);
    n_checks++; if (rd !== 32'hDEAD55EF) begin n_fail++; $display("FAIL sb_lanes: got %h expected dead55ef", rd); end
    run_txn(1'b1, 32'h12, 32'hABCD1234, 3'b001, lat, rd, er, ok);
    run_txn(1'b0, 32'h10, 32'd0, 3'b010, lat, rd, er, ok);
    n_checks++; if (rd !== 32'h123455EF) begin n_fail++; $display("FAIL sh_lanes: got %h expected 123455ef", rd); end
    run_txn(1'b1, 32'hFC, 32'h600DCAFE, 3'b010, lat, rd, er, ok);
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL sw_last_word: err got %b expected 0", er); end
    run_txn(1'b0, 32'hFC, 32'd0, 3'b010, lat, rd, er, ok);
    n_checks++; if (rd !== 32'h600DCAFE || er) begin n_fail++; $display("FAIL lw_last_word: got %h expected 600dcafe", rd); end
  endtask

  task automatic test_errors;
    int lat; logic [31:0] rd; logic er, ok;
    sel = 2;
    run_txn(1'b0, 32'h12, 32'd0, 3'b010, lat, rd, er, ok);
    n_checks++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL lw_misaligned: err=%b rdata=%h expected 1/0", er, rd); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL err_latency: got %0d expected 2", lat); end
    run_txn(1'b1, 32'h11, 32'h0000BBBB, 3'b001, lat, rd, er, ok);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL sh_misaligned: err got %b expected 1", er); end
    run_txn(1'b0, 32'h10, 32'd0, 3'b010, lat, rd, er, ok);
    n_checks++; if (rd !== 32'h123455EF) begin n_fail++; $display("FAIL err_no_write: got %h expected 123455ef", rd); end
    run_txn(1'b0, 32'h100, 32'd0, 3'b010, lat, rd, er, ok);
    n_checks++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL out_of_range: err=%b rdata=%h expected 1/0", er, rd); end
    run_txn(1'b0, 32'h10, 32'd0, 3'b011, lat, rd, er, ok);
    n_checks++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL funct3_011: err=%b rdata=%h expected 1/0", er, rd); end
    run_txn(1'b1, 32'h10, 32'h77777777, 3'b100, lat, rd, er, ok);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL store_bu: err got %b expected 1", er); end
    run_txn(1'b0, 32'h10, 32'd0, 3'b010, lat, rd, er, ok);
    n_checks++; if (rd !== 32'h123455EF) begin n_fail++; $display("FAIL store_bu_no_write: got %h expected 123455ef", rd); end
  endtask

  task automatic test_reset_abort;
    int lat; logic [31:0] rd; logic er, ok;
    sel = 3;
    run_txn(1'b1, 32'h20, 32'h11223344, 3'b010, lat, rd, er, ok);
    n_checks++; if (lat !== 3 || er) begin n_fail++; $display("FAIL lat3_sw: cycles=%0d err=%b expected 3/0", lat, er); end
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5; req_funct3 = 3'b010; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0 || m_ready !== 1'b1 || m_busy !== 1'b0) begin n_fail++; $display("FAIL abort_reset: valid=%b ready=%b busy=%b expected 0/1/0", m_valid, m_ready, m_busy); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) reset = 1'b1;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_rsp: cycle %0d valid=%b expected 0", i, m_valid); end
    end
    run_txn(1'b0, 32'h20, 32'd0, 3'b010, lat, rd, er, ok);
    n_checks++; if (rd !== 32'h11223344 || er) begin n_fail++; $display("FAIL abort_no_write: got %h expected 11223344", rd); end
  endtask

  task automatic test_back_to_back;
    logic        op_we [4];
    logic [31:0] op_wd [4];
    logic [31:0] op_exp [4];
    logic        ev;
    int          k;
    op_we[0] = 1'b1; op_wd[0] = 32'hCAFEF00D; op_exp[0] = 32'd0;
    op_we[1] = 1'b0; op_wd[1] = 32'd0;        op_exp[1] = 32'hCAFEF00D;
    op_we[2] = 1'b1; op_wd[2] = 32'h0BADF00D; op_exp[2] = 32'd0;
    op_we[3] = 1'b0; op_wd[3] = 32'd0;        op_exp[3] = 32'h0BADF00D;
    sel = 1; k = 0;
    @(negedge clk);
    req_we = op_we[0]; req_addr = 32'h40; req_wdata = op_wd[0]; req_funct3 = 3'b010; req_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      ev = (i % 2) == 1;
      n_checks++; if (m_valid !== ev) begin n_fail++; $display("FAIL b2b_valid: cycle %0d got %b expected %b", i, m_valid, ev); end
      n_checks++; if (m_ready !== !ev) begin n_fail++; $display("FAIL b2b_ready: cycle %0d got %b expected %b", i, m_ready, !ev); end
      if (m_valid && k < 4) begin
        $display("txn lat1 b2b op=%0d we=%0b -> rdata=%h", k, op_we[k], m_rdata);
        n_checks++; if (m_rdata !== op_exp[k]) begin n_fail++; $display("FAIL b2b_rdata: op %0d got %h expected %h", k, m_rdata, op_exp[k]); end
        k++;
        if (k < 4) begin req_we = op_we[k]; req_wdata = op_wd[k]; end
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    n_checks++; if (k !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d responses expected 4", k); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_partial_store();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
